// File: rtl/spu_fwd_wb_if.sv
// Bundles the insert, lookup, writeback and flush signals of the SPU forwarding/writeback stage.
interface spu_fwd_wb_if #(
    parameter int WIDTH   = 128,
    parameter int REGBITS = 7
);
    logic               flush;
    logic               ev_valid;
    logic [REGBITS-1:0] ev_rt;
    logic [2:0]         ev_lat;
    logic [WIDTH-1:0]   ev_data;
    logic               od_valid;
    logic [REGBITS-1:0] od_rt;
    logic [2:0]         od_lat;
    logic [WIDTH-1:0]   od_data;
    logic [REGBITS-1:0] ra1;
    logic [REGBITS-1:0] ra2;
    logic               fwd1_hit;
    logic [WIDTH-1:0]   fwd1_data;
    logic               fwd2_hit;
    logic [WIDTH-1:0]   fwd2_data;
    logic               stall;
    logic               ev_wb_en;
    logic [REGBITS-1:0] ev_wb_addr;
    logic [WIDTH-1:0]   ev_wb_data;
    logic               od_wb_en;
    logic [REGBITS-1:0] od_wb_addr;
    logic [WIDTH-1:0]   od_wb_data;
    logic               collide;

    modport master (
        output flush, ev_valid, ev_rt, ev_lat, ev_data,
        output od_valid, od_rt, od_lat, od_data, ra1, ra2,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, stall,
        input  ev_wb_en, ev_wb_addr, ev_wb_data,
        input  od_wb_en, od_wb_addr, od_wb_data, collide
    );

    modport slave (
        input  flush, ev_valid, ev_rt, ev_lat, ev_data,
        input  od_valid, od_rt, od_lat, od_data, ra1, ra2,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, stall,
        output ev_wb_en, ev_wb_addr, ev_wb_data,
        output od_wb_en, od_wb_addr, od_wb_data, collide
    );
endinterface

// File: rtl/spu_fwd_wb.sv
// SPU even/odd result staging: per-pipe shift pipelines, operand forwarding with
// youngest-match stall detection, and one regfile write per pipe at the last stage.
module spu_fwd_wb #(
    parameter int WIDTH   = 128,
    parameter int REGBITS = 7,
    parameter int DEPTH   = 7
) (
    input logic         clk,
    input logic         rst_n,
    spu_fwd_wb_if.slave bus
);
    localparam logic [2:0] MAX_CNT = 3'(DEPTH - 1);

    logic               ev_v      [DEPTH];
    logic [REGBITS-1:0] ev_rt_q   [DEPTH];
    logic [2:0]         ev_cnt    [DEPTH];
    logic [WIDTH-1:0]   ev_data_q [DEPTH];
    logic               od_v      [DEPTH];
    logic [REGBITS-1:0] od_rt_q   [DEPTH];
    logic [2:0]         od_cnt    [DEPTH];
    logic [WIDTH-1:0]   od_data_q [DEPTH];
    logic               collide_q;

    logic [2:0]         ev_lat_c;
    logic [2:0]         od_lat_c;
    logic               wb_conflict;
    logic               f1, r1, f2, r2;
    logic [WIDTH-1:0]   d1, d2;

    // Clamp latencies so every entry is ready by the writeback stage
    always_comb begin
        ev_lat_c = (bus.ev_lat > MAX_CNT) ? MAX_CNT : bus.ev_lat;
        od_lat_c = (bus.od_lat > MAX_CNT) ? MAX_CNT : bus.od_lat;
    end

    // Same-rt pair about to reach the writeback stage: odd keeps the write
    assign wb_conflict = ev_v[DEPTH-2] & od_v[DEPTH-2] &
                         (ev_rt_q[DEPTH-2] == od_rt_q[DEPTH-2]);

    // Insert, shift and count down both pipes; invalid entries are held all-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ev_v[i] <= 1'b0; ev_rt_q[i] <= '0; ev_cnt[i] <= '0; ev_data_q[i] <= '0;
                od_v[i] <= 1'b0; od_rt_q[i] <= '0; od_cnt[i] <= '0; od_data_q[i] <= '0;
            end
            collide_q <= 1'b0;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ev_v[i] <= 1'b0; ev_rt_q[i] <= '0; ev_cnt[i] <= '0; ev_data_q[i] <= '0;
                od_v[i] <= 1'b0; od_rt_q[i] <= '0; od_cnt[i] <= '0; od_data_q[i] <= '0;
            end
            collide_q <= 1'b0;
        end else begin
            ev_v[0]      <= bus.ev_valid;
            ev_rt_q[0]   <= bus.ev_valid ? bus.ev_rt   : '0;
            ev_cnt[0]    <= bus.ev_valid ? ev_lat_c    : '0;
            ev_data_q[0] <= bus.ev_valid ? bus.ev_data : '0;
            od_v[0]      <= bus.od_valid;
            od_rt_q[0]   <= bus.od_valid ? bus.od_rt   : '0;
            od_cnt[0]    <= bus.od_valid ? od_lat_c    : '0;
            od_data_q[0] <= bus.od_valid ? bus.od_data : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                ev_v[i]      <= ev_v[i-1];
                ev_rt_q[i]   <= ev_rt_q[i-1];
                ev_cnt[i]    <= (ev_cnt[i-1] == 3'd0) ? 3'd0 : ev_cnt[i-1] - 3'd1;
                ev_data_q[i] <= ev_data_q[i-1];
                od_v[i]      <= od_v[i-1];
                od_rt_q[i]   <= od_rt_q[i-1];
                od_cnt[i]    <= (od_cnt[i-1] == 3'd0) ? 3'd0 : od_cnt[i-1] - 3'd1;
                od_data_q[i] <= od_data_q[i-1];
            end
            // The losing even entry is dropped on entry to the last stage so the
            // write port stays register-driven; lookups never see it because the
            // odd entry in the same stage with the same rt always wins.
            if (wb_conflict) begin
                ev_v[DEPTH-1]      <= 1'b0;
                ev_rt_q[DEPTH-1]   <= '0;
                ev_cnt[DEPTH-1]    <= '0;
                ev_data_q[DEPTH-1] <= '0;
            end
            collide_q <= bus.ev_valid & bus.od_valid & (bus.ev_rt == bus.od_rt);
        end
    end

    // Operand lookup: walk oldest to youngest, even before odd, so the last match wins
    always_comb begin
        f1 = 1'b0; r1 = 1'b0; d1 = '0;
        f2 = 1'b0; r2 = 1'b0; d2 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (ev_v[DEPTH-1-k] && ev_rt_q[DEPTH-1-k] == bus.ra1) begin
                f1 = 1'b1; r1 = (ev_cnt[DEPTH-1-k] == 3'd0); d1 = ev_data_q[DEPTH-1-k];
            end
            if (od_v[DEPTH-1-k] && od_rt_q[DEPTH-1-k] == bus.ra1) begin
                f1 = 1'b1; r1 = (od_cnt[DEPTH-1-k] == 3'd0); d1 = od_data_q[DEPTH-1-k];
            end
            if (ev_v[DEPTH-1-k] && ev_rt_q[DEPTH-1-k] == bus.ra2) begin
                f2 = 1'b1; r2 = (ev_cnt[DEPTH-1-k] == 3'd0); d2 = ev_data_q[DEPTH-1-k];
            end
            if (od_v[DEPTH-1-k] && od_rt_q[DEPTH-1-k] == bus.ra2) begin
                f2 = 1'b1; r2 = (od_cnt[DEPTH-1-k] == 3'd0); d2 = od_data_q[DEPTH-1-k];
            end
        end
    end

    assign bus.fwd1_hit   = f1 & r1;
    assign bus.fwd1_data  = (f1 & r1) ? d1 : '0;
    assign bus.fwd2_hit   = f2 & r2;
    assign bus.fwd2_data  = (f2 & r2) ? d2 : '0;
    assign bus.stall      = (f1 & ~r1) | (f2 & ~r2);
    assign bus.ev_wb_en   = ev_v[DEPTH-1];
    assign bus.ev_wb_addr = ev_rt_q[DEPTH-1];
    assign bus.ev_wb_data = ev_data_q[DEPTH-1];
    assign bus.od_wb_en   = od_v[DEPTH-1];
    assign bus.od_wb_addr = od_rt_q[DEPTH-1];
    assign bus.od_wb_data = od_data_q[DEPTH-1];
    assign bus.collide    = collide_q;
endmodule

// File: tb/tb_spu_fwd_wb.sv
// Bench for spu_fwd_wb: directed scenarios plus randomized traffic against a
// transaction-list reference model, run on a DEPTH=7 and a DEPTH=4 instance.
module tb_spu_fwd_wb;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush, ev_valid, od_valid;
    logic [6:0]   ev_rt, od_rt, ra1, ra2;
    logic [2:0]   ev_lat, od_lat;
    logic [127:0] ev_data, od_data;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spu_fwd_wb_if #(.WIDTH(128), .REGBITS(7)) if7 ();
    spu_fwd_wb_if #(.WIDTH(128), .REGBITS(7)) if4 ();

    assign if7.flush = flush;     assign if4.flush = flush;
    assign if7.ev_valid = ev_valid; assign if4.ev_valid = ev_valid;
    assign if7.ev_rt = ev_rt;     assign if4.ev_rt = ev_rt;
    assign if7.ev_lat = ev_lat;   assign if4.ev_lat = ev_lat;
    assign if7.ev_data = ev_data; assign if4.ev_data = ev_data;
    assign if7.od_valid = od_valid; assign if4.od_valid = od_valid;
    assign if7.od_rt = od_rt;     assign if4.od_rt = od_rt;
    assign if7.od_lat = od_lat;   assign if4.od_lat = od_lat;
    assign if7.od_data = od_data; assign if4.od_data = od_data;
    assign if7.ra1 = ra1;         assign if4.ra1 = ra1;
    assign if7.ra2 = ra2;         assign if4.ra2 = ra2;

    spu_fwd_wb #(.WIDTH(128), .REGBITS(7), .DEPTH(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(if7));
    spu_fwd_wb #(.WIDTH(128), .REGBITS(7), .DEPTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    // Reference model: list of live inserts, each tagged with the edge that captured it.
    typedef struct {
        bit           odd;
        logic [6:0]   rt;
        int           lat;
        logic [127:0] data;
        int           cyc;
    } ent_t;

    ent_t q[$];
    int   ncyc = 0;
    bit   exp_collide = 1'b0;

    function automatic void look(input int d, input logic [6:0] ra, output bit found,
                                 output bit rdy, output logic [127:0] data);
        int bs;
        found = 1'b0; rdy = 1'b0; data = '0; bs = 0;
        foreach (q[i]) begin
            int s;
            s = ncyc - q[i].cyc - 1;
            if (s < d && q[i].rt == ra && (!found || s < bs || (s == bs && q[i].odd))) begin
                found = 1'b1;
                bs    = s;
                rdy   = (s >= ((q[i].lat < d - 1) ? q[i].lat : d - 1));
                data  = q[i].data;
            end
        end
    endfunction

    function automatic void wb(input int d, input bit odd, output bit en,
                               output logic [6:0] a, output logic [127:0] dat);
        en = 1'b0; a = '0; dat = '0;
        foreach (q[i])
            if (ncyc - q[i].cyc - 1 == d - 1 && q[i].odd == odd) begin
                en = 1'b1; a = q[i].rt; dat = q[i].data;
            end
        if (!odd && en)
            foreach (q[i])
                if (ncyc - q[i].cyc - 1 == d - 1 && q[i].odd && q[i].rt == a) begin
                    en = 1'b0; a = '0; dat = '0;
                end
    endfunction

    function automatic logic [531:0] expect_vec(input int d);
        bit f1, r1, f2, r2, ee, oe;
        logic [127:0] d1, d2, ed, od;
        logic [6:0] ea, oa;
        look(d, ra1, f1, r1, d1);
        look(d, ra2, f2, r2, d2);
        wb(d, 1'b0, ee, ea, ed);
        wb(d, 1'b1, oe, oa, od);
        return {f1 && r1, (f1 && r1) ? d1 : 128'd0, f2 && r2, (f2 && r2) ? d2 : 128'd0,
                (f1 && !r1) || (f2 && !r2), ee, ea, ed, oe, oa, od, exp_collide};
    endfunction

    task automatic tick();
        ent_t e;
        if (flush) q.delete();
        else begin
            if (ev_valid) begin
                e.odd = 1'b0; e.rt = ev_rt; e.lat = int'(ev_lat); e.data = ev_data; e.cyc = ncyc;
                q.push_back(e);
            end
            if (od_valid) begin
                e.odd = 1'b1; e.rt = od_rt; e.lat = int'(od_lat); e.data = od_data; e.cyc = ncyc;
                q.push_back(e);
            end
        end
        exp_collide = !flush && ev_valid && od_valid && (ev_rt == od_rt);
        @(posedge clk);
        ncyc++;
        #1;
        for (int i = q.size() - 1; i >= 0; i--)
            if (ncyc - q[i].cyc - 1 >= 8) q.delete(i);
    endtask

    task automatic idle();
        flush = 1'b0; ev_valid = 1'b0; od_valid = 1'b0;
    endtask

    task automatic drain();
        idle(); flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        ev_rt = '0; od_rt = '0; ev_lat = '0; od_lat = '0; ev_data = '0; od_data = '0;
        ra1 = 7'd1; ra2 = 7'd3;
        #3;
        n_total++; if ({if7.fwd1_hit, if7.stall, if7.ev_wb_en, if7.od_wb_en, if7.collide, if7.ev_wb_data} !== '0)
            $display("FAIL reset_initial got nonzero outputs exp all zero"); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        ev_valid = 1'b1; ev_rt = 7'd1; ev_lat = 3'd0; ev_data = 128'h11;
        od_valid = 1'b1; od_rt = 7'd3; od_lat = 3'd0; od_data = 128'h33;
        tick();
        od_valid = 1'b0; ev_rt = 7'd2; ev_data = 128'h22;
        tick();
        idle();
        #1;
        n_total++; if (if7.fwd1_hit !== 1'b1) $display("FAIL reset_inflight_hit got %b exp 1", if7.fwd1_hit); else n_pass++;
        rst_n = 1'b0;
        #1;
        q.delete(); exp_collide = 1'b0;
        n_total++; if ({if7.fwd1_hit, if7.fwd1_data, if7.fwd2_hit, if7.fwd2_data, if7.stall, if7.ev_wb_en,
                        if7.ev_wb_addr, if7.ev_wb_data, if7.od_wb_en, if7.od_wb_addr, if7.od_wb_data, if7.collide} !== expect_vec(7))
            $display("FAIL reset_async_outputs got nonzero exp all zero"); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_total++; if ({if7.ev_wb_en, if7.od_wb_en, if4.ev_wb_en, if4.od_wb_en} !== 4'b0)
                $display("FAIL reset_no_wb c=%0d got %b exp 0000", c, {if7.ev_wb_en, if7.od_wb_en, if4.ev_wb_en, if4.od_wb_en}); else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic [127:0] a;
        a = {$urandom, $urandom, $urandom, $urandom};
        idle();
        ev_valid = 1'b1; ev_rt = 7'd5; ev_lat = 3'd2; ev_data = a; ra1 = 7'd5; ra2 = 7'd100;
        #1;
        n_total++; if (if7.stall !== 1'b0) $display("FAIL latency_c0_stall got %b exp 0", if7.stall); else n_pass++;
        tick();
        idle();
        for (int c = 1; c <= 8; c++) begin
            #1;
            n_total++; if (if7.stall !== (c <= 2)) $display("FAIL latency_stall c=%0d got %b exp %b", c, if7.stall, c <= 2); else n_pass++;
            if (c != 7) begin
                n_total++; if (if7.fwd1_hit !== (c >= 3 && c <= 6) || if7.fwd1_data !== ((c >= 3 && c <= 6) ? a : 128'd0))
                    $display("FAIL latency_fwd c=%0d got %b/%h exp %b", c, if7.fwd1_hit, if7.fwd1_data, c >= 3 && c <= 6); else n_pass++;
            end
            n_total++; if (if7.ev_wb_en !== (c == 7) || if7.ev_wb_addr !== ((c == 7) ? 7'd5 : 7'd0) || if7.ev_wb_data !== ((c == 7) ? a : 128'd0))
                $display("FAIL latency_wb c=%0d got %b/%0d/%h exp en=%b", c, if7.ev_wb_en, if7.ev_wb_addr, if7.ev_wb_data, c == 7); else n_pass++;
            tick();
        end
    endtask

    task automatic test_youngest();
        logic [127:0] b, cdat;
        b = {$urandom, $urandom, $urandom, $urandom};
        cdat = {$urandom, $urandom, $urandom, $urandom};
        drain();
        ev_valid = 1'b1; ev_rt = 7'd9; ev_lat = 3'd0; ev_data = b; ra1 = 7'd100; ra2 = 7'd9;
        tick();
        idle();
        od_valid = 1'b1; od_rt = 7'd9; od_lat = 3'd4; od_data = cdat;
        #1;
        n_total++; if (if7.fwd2_hit !== 1'b1 || if7.fwd2_data !== b || if7.stall !== 1'b0)
            $display("FAIL youngest_c1 got %b/%h/%b exp 1/%h/0", if7.fwd2_hit, if7.fwd2_data, if7.stall, b); else n_pass++;
        tick();
        idle();
        for (int c = 2; c <= 6; c++) begin
            #1;
            n_total++; if (if7.stall !== (c <= 5) || if7.fwd2_hit !== (c == 6) || if7.fwd2_data !== ((c == 6) ? cdat : 128'd0))
                $display("FAIL youngest c=%0d got stall=%b hit=%b data=%h", c, if7.stall, if7.fwd2_hit, if7.fwd2_data); else n_pass++;
            tick();
        end
    endtask

    task automatic test_same_rt();
        drain();
        ev_valid = 1'b1; ev_rt = 7'd12; ev_lat = 3'd0; ev_data = 128'hDDDD;
        od_valid = 1'b1; od_rt = 7'd12; od_lat = 3'd0; od_data = 128'hEEEE;
        ra1 = 7'd12; ra2 = 7'd100;
        tick();
        idle();
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c <= 2) begin
                n_total++; if (if7.collide !== (c == 1)) $display("FAIL same_rt_collide c=%0d got %b exp %b", c, if7.collide, c == 1); else n_pass++;
            end
            if (c <= 6) begin
                n_total++; if (if7.fwd1_hit !== 1'b1 || if7.fwd1_data !== 128'hEEEE)
                    $display("FAIL same_rt_fwd c=%0d got %b/%h exp 1/eeee", c, if7.fwd1_hit, if7.fwd1_data); else n_pass++;
            end
            n_total++; if (if7.ev_wb_en !== 1'b0 || if7.ev_wb_data !== 128'd0 || if7.od_wb_en !== (c == 7) || if7.od_wb_data !== ((c == 7) ? 128'hEEEE : 128'd0))
                $display("FAIL same_rt_wb c=%0d got ev=%b od=%b/%h", c, if7.ev_wb_en, if7.od_wb_en, if7.od_wb_data); else n_pass++;
            tick();
        end
    endtask

    task automatic test_lat_clamp();
        drain();
        ev_valid = 1'b1; ev_rt = 7'd20; ev_lat = 3'd7; ev_data = 128'hF00D; ra1 = 7'd20; ra2 = 7'd100;
        tick();
        idle();
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_total++; if (if4.stall !== (c <= 3) || if4.fwd1_hit !== (c == 4))
                $display("FAIL lat_clamp_ready c=%0d got stall=%b hit=%b", c, if4.stall, if4.fwd1_hit); else n_pass++;
            if (c == 4) begin
                n_total++; if (if4.ev_wb_en !== 1'b1 || if4.ev_wb_data !== 128'hF00D || if4.fwd1_data !== 128'hF00D)
                    $display("FAIL lat_clamp_wb got en=%b wb=%h fwd=%h exp 1/f00d/f00d", if4.ev_wb_en, if4.ev_wb_data, if4.fwd1_data); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drain();
        ev_valid = 1'b1; ev_rt = 7'd30; ev_lat = 3'd0; ev_data = 128'h30;
        od_valid = 1'b1; od_rt = 7'd31; od_lat = 3'd0; od_data = 128'h31;
        tick();
        ev_rt = 7'd32; ev_data = 128'h32; od_rt = 7'd33; od_lat = 3'd5; od_data = 128'h33;
        ra1 = 7'd30; ra2 = 7'd33;
        tick();
        flush = 1'b1; ev_valid = 1'b1; od_valid = 1'b0; ev_rt = 7'd30; ev_lat = 3'd0; ev_data = 128'hBAD;
        #1;
        n_total++; if (if7.fwd1_hit !== 1'b1 || if7.fwd1_data !== 128'h30 || if7.stall !== 1'b1)
            $display("FAIL flush_same_cycle got %b/%h/%b exp 1/30/1", if7.fwd1_hit, if7.fwd1_data, if7.stall); else n_pass++;
        tick();
        idle();
        #1;
        n_total++; if ({if7.fwd1_hit, if7.fwd2_hit, if7.stall, if4.fwd1_hit, if4.fwd2_hit, if4.stall} !== 6'b0)
            $display("FAIL flush_lookup got %b exp 000000", {if7.fwd1_hit, if7.fwd2_hit, if7.stall, if4.fwd1_hit, if4.fwd2_hit, if4.stall}); else n_pass++;
        for (int c = 0; c < 9; c++) begin
            n_total++; if ({if7.ev_wb_en, if7.od_wb_en, if4.ev_wb_en, if4.od_wb_en} !== 4'b0)
                $display("FAIL flush_wb c=%0d got %b exp 0000", c, {if7.ev_wb_en, if7.od_wb_en, if4.ev_wb_en, if4.od_wb_en}); else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [531:0] got7, got4, exp7, exp4;
        drain();
        for (int c = 0; c < 400; c++) begin
            flush    = ($urandom_range(0, 39) == 0);
            ev_valid = ($urandom_range(0, 9) < 6);
            od_valid = ($urandom_range(0, 9) < 6);
            ev_rt    = 7'($urandom_range(0, 7));
            od_rt    = 7'($urandom_range(0, 7));
            ev_lat   = 3'($urandom_range(0, 7));
            od_lat   = 3'($urandom_range(0, 7));
            ev_data  = {$urandom, $urandom, $urandom, $urandom};
            od_data  = {$urandom, $urandom, $urandom, $urandom};
            ra1      = 7'($urandom_range(0, 7));
            ra2      = 7'($urandom_range(0, 7));
            #1;
            got7 = {if7.fwd1_hit, if7.fwd1_data, if7.fwd2_hit, if7.fwd2_data, if7.stall, if7.ev_wb_en, if7.ev_wb_addr,
                    if7.ev_wb_data, if7.od_wb_en, if7.od_wb_addr, if7.od_wb_data, if7.collide};
            got4 = {if4.fwd1_hit, if4.fwd1_data, if4.fwd2_hit, if4.fwd2_data, if4.stall, if4.ev_wb_en, if4.ev_wb_addr,
                    if4.ev_wb_data, if4.od_wb_en, if4.od_wb_addr, if4.od_wb_data, if4.collide};
            exp7 = expect_vec(7);
            exp4 = expect_vec(4);
            n_total++; if (got7 !== exp7) $display("FAIL random_d7 c=%0d got %h exp %h", c, got7, exp7); else n_pass++;
            n_total++; if (got4 !== exp4) $display("FAIL random_d4 c=%0d got %h exp %h", c, got4, exp4); else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_youngest();
        test_same_rt();
        test_lat_clamp();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
